// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned reads, buffers one instruction for the
// decoder, and flushes in-flight data on redirect by draining the abandoned request.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4
);

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } state_t;

  localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] drop_addr;
  logic        buf_valid;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc;
  logic        transfer;

  assign inst_valid    = buf_valid & ~rst;
  assign instruction   = buf_inst;
  assign inst_pc       = buf_pc;
  assign inst_pc_plus4 = buf_pc + 32'd4;
  assign transfer      = inst_valid & inst_ready;

  // A full buffer only blocks a new request when the decoder is not draining it.
  assign imem_req  = ~rst & ((state == FETCH && (!inst_valid || inst_ready)) || state == DROP);
  assign imem_addr = rst ? RESET_ADDR : (state == DROP ? drop_addr : pc);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = (imem_req && !imem_ack) ? DROP : FETCH;
    end else if (state == DROP && imem_ack) begin
      state_next = FETCH;
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_ADDR;
      drop_addr <= RESET_ADDR;
      buf_valid <= 1'b0;
      buf_inst  <= 32'h0;
      buf_pc    <= 32'h0;
    end else begin
      state <= state_next;
      if (redirect) begin
        pc        <= {redirect_pc[31:2], 2'b00};
        buf_valid <= 1'b0;
        // In DROP the abandoned address is already held; only capture it from FETCH.
        if (state == FETCH) drop_addr <= imem_addr;
      end else if (state == FETCH && imem_req && imem_ack) begin
        buf_inst  <= imem_rdata;
        buf_pc    <= pc;
        buf_valid <= 1'b1;
        pc        <= pc + 32'd4;
      end else if (transfer) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirect/drop, wrap and reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;

  int n_checks = 0;
  int n_fails  = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .instruction   (instruction),
    .inst_pc       (inst_pc),
    .inst_pc_plus4 (inst_pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; redirect = 1'b0;
    redirect_pc = 32'h0; inst_ready = 1'b0;
    tick(); tick();
    check("rst_req",   {31'b0, imem_req},   32'h0);
    check("rst_addr",  imem_addr,           32'h0);
    check("rst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_inst",  instruction,         32'h0);
    check("rst_pc",    inst_pc,             32'h0);
    check("rst_pc4",   inst_pc_plus4,       32'h4);

    // Streaming: ack every cycle, decoder always ready.
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h2008_0005; inst_ready = 1'b1; #1;
    check("str_req0",  {31'b0, imem_req},   32'h1);
    check("str_addr0", imem_addr,           32'h0);
    check("str_val0",  {31'b0, inst_valid}, 32'h0);
    tick(); imem_rdata = 32'h0109_5020; #1;
    check("str_addr1", imem_addr,           32'h4);
    check("str_val1",  {31'b0, inst_valid}, 32'h1);
    check("str_inst1", instruction,         32'h2008_0005);
    check("str_pc1",   inst_pc,             32'h0);
    tick(); imem_rdata = 32'hAC0A_0000; #1;
    check("str_addr2", imem_addr,           32'h8);
    check("str_inst2", instruction,         32'h0109_5020);
    check("str_pc2",   inst_pc,             32'h4);
    tick(); imem_ack = 1'b0; #1;
    check("str_inst3", instruction,         32'hAC0A_0000);
    check("str_pc3",   inst_pc,             32'h8);

    // Backpressure: restart, hold one instruction with the decoder stalled.
    rst = 1'b1; tick();
    rst = 1'b0; inst_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    tick();
    imem_rdata = 32'hBAD0_BAD0;  // ack with no request must be ignored
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", {31'b0, inst_valid}, 32'h1);
      check("bp_req",   {31'b0, imem_req},   32'h0);
      check("bp_inst",  instruction,         32'h2008_0005);
      check("bp_pc",    inst_pc,             32'h0);
      check("bp_pc4",   inst_pc_plus4,       32'h4);
      tick();
    end
    imem_ack = 1'b0; inst_ready = 1'b1; #1;
    check("bp_rel_req",  {31'b0, imem_req}, 32'h1);
    check("bp_rel_addr", imem_addr,         32'h4);
    tick();
    check("bp_drained", {31'b0, inst_valid}, 32'h0);
    check("bp_hold_addr", imem_addr,         32'h4);

    // Redirect while the request at 0x8 is pending.
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111; tick();
    imem_ack = 1'b0; tick();
    check("rd_addr8", imem_addr,           32'h8);
    check("rd_val0",  {31'b0, inst_valid}, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h0000_0100; tick();
    redirect = 1'b0; #1;
    check("rd_drop_req",  {31'b0, imem_req}, 32'h1);
    check("rd_drop_addr", imem_addr,         32'h8);
    tick();
    check("rd_drop_addr2", imem_addr, 32'h8);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick();
    imem_ack = 1'b0; #1;
    check("rd_dropped",  {31'b0, inst_valid}, 32'h0);
    check("rd_new_addr", imem_addr,           32'h100);
    check("rd_new_req",  {31'b0, imem_req},   32'h1);
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222; tick();
    imem_ack = 1'b0; #1;
    check("rd_val",  {31'b0, inst_valid}, 32'h1);
    check("rd_pc",   inst_pc,             32'h100);
    check("rd_inst", instruction,         32'h2222_2222);

    // Redirect coinciding with an ack while the buffer holds a valid instruction.
    redirect = 1'b1; redirect_pc = 32'h0000_0203; imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
    tick();
    redirect = 1'b0; imem_ack = 1'b0; #1;
    check("co_valid", {31'b0, inst_valid}, 32'h0);
    check("co_addr",  imem_addr,           32'h200);
    check("co_req",   {31'b0, imem_req},   32'h1);

    // Wrap: redirect to the last word, discarding the coincident ack.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
    tick();
    redirect = 1'b0; imem_rdata = 32'h5555_5555; #1;
    check("wr_valid0", {31'b0, inst_valid}, 32'h0);
    check("wr_addr0",  imem_addr,           32'hFFFF_FFFC);
    tick(); imem_rdata = 32'h6666_6666; #1;
    check("wr_addr1", imem_addr,     32'h0);
    check("wr_pc",    inst_pc,       32'hFFFF_FFFC);
    check("wr_pc4",   inst_pc_plus4, 32'h0);
    check("wr_inst",  instruction,   32'h5555_5555);
    tick(); imem_ack = 1'b0; #1;
    check("wr_pc_b", inst_pc,     32'h0);
    check("wr_inst_b", instruction, 32'h6666_6666);

    // Reset in DROP: redirect with the buffer valid and a request pending, then reset.
    redirect = 1'b1; redirect_pc = 32'h0000_0300; tick();
    redirect = 1'b0; #1;
    check("rs_drop_addr", imem_addr, 32'h4);
    check("rs_drop_req",  {31'b0, imem_req}, 32'h1);
    rst = 1'b1; #1;
    check("rs_req_now",  {31'b0, imem_req}, 32'h0);
    check("rs_addr_now", imem_addr,         32'h0);
    tick();
    check("rs_valid", {31'b0, inst_valid}, 32'h0);
    check("rs_req",   {31'b0, imem_req},   32'h0);
    check("rs_addr",  imem_addr,           32'h0);
    check("rs_inst",  instruction,         32'h0);
    rst = 1'b0; #1;
    check("rs_first_req",  {31'b0, imem_req}, 32'h1);
    check("rs_first_addr", imem_addr,         32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h7777_7777; tick();
    imem_ack = 1'b0; #1;
    check("rs_first_pc",   inst_pc,     32'h0);
    check("rs_first_inst", instruction, 32'h7777_7777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
